// File: rtl/seq_div_pkg.sv
// Shared types and sizing helpers for the sequential restoring divider.
package seq_div_pkg;

  localparam int DEF_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  // Bit counter must hold the value WIDTH itself, not just WIDTH-1.
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/seq_div_step.sv
// One combinational restoring-division step: shift {R,Q} left, trial-subtract D,
// keep the difference and set the quotient bit when it does not go negative.
module seq_div_step
  import seq_div_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH:0]   r,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH:0]   r_next,
  output logic [WIDTH-1:0] q_next
);

  logic [WIDTH+1:0] r_shift;
  logic [WIDTH+1:0] trial;

  // One extra guard bit so the borrow lands in a dedicated sign bit.
  assign r_shift = {r, q[WIDTH-1]};
  assign trial   = r_shift - {2'b00, d};

  always_comb begin
    r_next = r_shift[WIDTH:0];
    q_next = {q[WIDTH-2:0], 1'b0};
    if (!trial[WIDTH+1]) begin
      r_next = trial[WIDTH:0];
      q_next = {q[WIDTH-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/seq_div.sv
// Sequential unsigned restoring divider, one quotient bit per clock.
// Optional SEQ_DIV_ZERO_CHK_EN: short-circuit divide-by-zero and flag it.
//
// state | meaning
// IDLE  | waiting for start; results held
// RUN   | one restoring step per clock, busy=1
// DONE  | single cycle with done=1, then back to IDLE
module seq_div
  import seq_div_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = cnt_width(WIDTH);

  state_t           state;
  logic [WIDTH:0]   r_reg;
  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] d_reg;
  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   r_next;
  logic [WIDTH-1:0] q_next;
  logic             zero_skip;

`ifdef SEQ_DIV_ZERO_CHK_EN
  assign zero_skip = (divisor == '0);
`else
  assign zero_skip = 1'b0;
`endif

  seq_div_step #(.WIDTH(WIDTH)) u_step (
    .r      (r_reg),
    .q      (q_reg),
    .d      (d_reg),
    .r_next (r_next),
    .q_next (q_next)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      r_reg       <= '0;
      q_reg       <= '0;
      d_reg       <= '0;
      cnt         <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            q_reg <= dividend;
            d_reg <= divisor;
            r_reg <= '0;
            cnt   <= CW'(WIDTH);
            if (zero_skip) begin
              state       <= DONE;
              done        <= 1'b1;
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
            end else begin
              state <= RUN;
              busy  <= 1'b1;
            end
          end
        end
        RUN: begin
          r_reg <= r_next;
          q_reg <= q_next;
          cnt   <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            state       <= DONE;
            busy        <= 1'b0;
            done        <= 1'b1;
            quotient    <= q_next;
            remainder   <= r_next[WIDTH-1:0];
            div_by_zero <= 1'b0;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_div.sv
// Self-checking bench for seq_div (WIDTH=4) against a plain-arithmetic model.
module tb_seq_div;

  localparam int W = 4;
  localparam int MAXV = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int errors = 0;
  int checks = 0;

  seq_div #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  function automatic int ref_q(input int a, input int b);
    return (b == 0) ? MAXV : a / b;
  endfunction

  function automatic int ref_r(input int a, input int b);
    return (b == 0) ? a : a % b;
  endfunction

  // Rising edges from accept until done is visible.
  function automatic int ref_lat(input int b);
`ifdef SEQ_DIV_ZERO_CHK_EN
    if (b == 0) return 0;
`endif
    return W;
  endfunction

  function automatic int ref_dbz(input int b);
`ifdef SEQ_DIV_ZERO_CHK_EN
    return (b == 0) ? 1 : 0;
`else
    return 0;
`endif
  endfunction

  // Pulses start for one cycle, then waits (bounded) for done; returns at that negedge.
  task automatic do_op(input int a, input int b, output int lat, output int busy_n,
                       output bit seen);
    @(negedge clk);
    dividend = W'(a);
    divisor  = W'(b);
    start    = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    lat    = 0;
    busy_n = 0;
    seen   = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (busy) busy_n++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++; if (quotient !== '0) begin errors++; $display("FAIL reset_q: got %0d expected 0", quotient); end
    checks++; if (remainder !== '0) begin errors++; $display("FAIL reset_r: got %0d expected 0", remainder); end
    checks++; if (div_by_zero !== 1'b0) begin errors++; $display("FAIL reset_dbz: got %b expected 0", div_by_zero); end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int lat, bn;
    bit seen;
    do_op(13, 3, lat, bn, seen);
    checks++; if (!seen) begin errors++; $display("FAIL basic_timeout: got no done expected done"); end
    checks++; if (lat != W) begin errors++; $display("FAIL basic_latency: got %0d expected %0d", lat, W); end
    checks++; if (bn != W) begin errors++; $display("FAIL basic_busy_cycles: got %0d expected %0d", bn, W); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_at_done: got %b expected 0", busy); end
    checks++; if (quotient !== 4'd4) begin errors++; $display("FAIL basic_q: got %0d expected 4", quotient); end
    checks++; if (remainder !== 4'd1) begin errors++; $display("FAIL basic_r: got %0d expected 1", remainder); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || quotient !== 4'd4 || remainder !== 4'd1) begin
        errors++;
        $display("FAIL basic_hold: got done=%b q=%0d r=%0d expected done=0 q=4 r=1", done, quotient, remainder);
      end
    end
  endtask

  task automatic test_vectors();
    int a_tab[12] = '{10, 9, 8, 7, 6, 5, 4, 3, 2, 1, 15, 0};
    int b_tab[12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 1, 7};
    int lat, bn;
    bit seen;
    for (int i = 0; i < 12; i++) begin
      do_op(a_tab[i], b_tab[i], lat, bn, seen);
      checks++;
      if (!seen || lat != W || int'(quotient) != ref_q(a_tab[i], b_tab[i]) ||
          int'(remainder) != ref_r(a_tab[i], b_tab[i]) || div_by_zero !== 1'b0) begin
        errors++;
        $display("FAIL vec_%0d_%0d: got seen=%0d lat=%0d q=%0d r=%0d dbz=%b expected lat=%0d q=%0d r=%0d dbz=0",
                 a_tab[i], b_tab[i], seen, lat, quotient, remainder, div_by_zero, W,
                 ref_q(a_tab[i], b_tab[i]), ref_r(a_tab[i], b_tab[i]));
      end
    end
  endtask

  task automatic test_div_zero();
    int lat, bn;
    bit seen;
    do_op(9, 0, lat, bn, seen);
    checks++; if (!seen || lat != ref_lat(0)) begin errors++; $display("FAIL dz_latency: got seen=%0d lat=%0d expected %0d", seen, lat, ref_lat(0)); end
    checks++; if (quotient !== 4'd15) begin errors++; $display("FAIL dz_q: got %0d expected 15", quotient); end
    checks++; if (remainder !== 4'd9) begin errors++; $display("FAIL dz_r: got %0d expected 9", remainder); end
    checks++; if (int'(div_by_zero) != ref_dbz(0)) begin errors++; $display("FAIL dz_flag: got %b expected %0d", div_by_zero, ref_dbz(0)); end
    do_op(9, 2, lat, bn, seen);
    checks++; if (div_by_zero !== 1'b0 || quotient !== 4'd4) begin errors++; $display("FAIL dz_clear: got dbz=%b q=%0d expected dbz=0 q=4", div_by_zero, quotient); end
  endtask

  task automatic test_random();
    int a, b, lat, bn;
    bit seen;
    for (int i = 0; i < 40; i++) begin
      a = int'($urandom_range(MAXV, 0));
      b = (i % 8 == 0) ? 0 : int'($urandom_range(MAXV, 0));
      do_op(a, b, lat, bn, seen);
      checks++;
      if (!seen || lat != ref_lat(b) || bn != ref_lat(b) || int'(quotient) != ref_q(a, b) ||
          int'(remainder) != ref_r(a, b) || int'(div_by_zero) != ref_dbz(b)) begin
        errors++;
        $display("FAIL rand_%0d_%0d: got seen=%0d lat=%0d busy=%0d q=%0d r=%0d dbz=%b expected lat=%0d q=%0d r=%0d dbz=%0d",
                 a, b, seen, lat, bn, quotient, remainder, div_by_zero, ref_lat(b),
                 ref_q(a, b), ref_r(a, b), ref_dbz(b));
      end
    end
  endtask

  task automatic test_ignored_start();
    int lat, ndone;
    bit seen;
    @(negedge clk);
    dividend = 4'd12; divisor = 4'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    dividend = 4'd3; divisor = 4'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 2; seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done) begin seen = 1'b1; break; end
      @(negedge clk);
      lat++;
    end
    checks++; if (!seen || lat != W) begin errors++; $display("FAIL ign_latency: got seen=%0d lat=%0d expected %0d", seen, lat, W); end
    checks++; if (quotient !== 4'd2 || remainder !== 4'd2) begin errors++; $display("FAIL ign_result: got q=%0d r=%0d expected q=2 r=2", quotient, remainder); end
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    checks++; if (ndone != 0) begin errors++; $display("FAIL ign_second_done: got %0d expected 0", ndone); end
  endtask

  task automatic test_reset_mid();
    int lat, bn, ndone;
    bit seen;
    @(negedge clk);
    dividend = 4'd14; divisor = 4'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || quotient !== '0 || remainder !== '0 || div_by_zero !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_clear: got busy=%b done=%b q=%0d r=%0d dbz=%b expected all 0",
               busy, done, quotient, remainder, div_by_zero);
    end
    ndone = 0;
    repeat (2) begin @(negedge clk); if (done) ndone++; end
    rst = 1'b0;
    repeat (W + 2) begin @(negedge clk); if (done) ndone++; end
    checks++; if (ndone != 0) begin errors++; $display("FAIL rst_mid_no_done: got %0d expected 0", ndone); end
    do_op(14, 3, lat, bn, seen);
    checks++;
    if (!seen || lat != W || quotient !== 4'd4 || remainder !== 4'd2) begin
      errors++;
      $display("FAIL rst_mid_rerun: got seen=%0d lat=%0d q=%0d r=%0d expected lat=%0d q=4 r=2",
               seen, lat, quotient, remainder, W);
    end
  endtask

  task automatic test_back_to_back();
    int idx[$];
    bit bad;
    @(negedge clk);
    dividend = 4'd11; divisor = 4'd2; start = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) begin
        idx.push_back(i);
        if (quotient !== 4'd5 || remainder !== 4'd1) bad = 1'b1;
      end
    end
    start = 1'b0;
    checks++; if (idx.size() < 5) begin errors++; $display("FAIL b2b_count: got %0d expected at least 5", idx.size()); end
    checks++; if (idx.size() > 0 && idx[0] != W) begin errors++; $display("FAIL b2b_first: got %0d expected %0d", idx[0], W); end
    for (int k = 1; k < idx.size(); k++) begin
      checks++;
      if (idx[k] - idx[k-1] != W + 2) begin
        errors++;
        $display("FAIL b2b_gap_%0d: got %0d expected %0d", k, idx[k] - idx[k-1], W + 2);
      end
    end
    checks++; if (bad) begin errors++; $display("FAIL b2b_result: got a wrong q/r expected q=5 r=1"); end
    repeat (W + 3) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_vectors();
    test_div_zero();
    test_random();
    test_ignored_start();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
